// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm sounder controller.
package alarm_pkg;

    localparam int TICKS_PER_SEC = 256;
    localparam int TIME_W        = 16;
    localparam int TICK_W        = 8;
    localparam int SECS_W        = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2,
        DONE    = 2'd3
    } alarm_state_e;

endpackage

// File: rtl/sec_timer.sv
// Tick/seconds counter shared by ring and snooze timing; flags the last cycle
// before the seconds count reaches the selected terminal value.
module sec_timer
    import alarm_pkg::*;
#(
    parameter int TICKS = TICKS_PER_SEC
) (
    input  logic              clk256,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              run,
    input  logic [SECS_W-1:0] term,
    output logic [TICK_W-1:0] tick_next,
    output logic              expire
);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS - 1);

    logic [TICK_W-1:0] tick;
    logic [SECS_W-1:0] secs;
    logic [SECS_W-1:0] secs_next;
    logic              sec_pulse;

    assign sec_pulse = run && (tick == TICK_LAST);
    assign expire    = sec_pulse && (secs == term - SECS_W'(1));

    always_comb begin
        tick_next = tick;
        secs_next = secs;
        if (clear) begin
            tick_next = '0;
            secs_next = '0;
        end else if (run) begin
            if (sec_pulse) begin
                tick_next = '0;
                secs_next = secs + SECS_W'(1);
            end else begin
                tick_next = tick + TICK_W'(1);
            end
        end
    end

    always_ff @(posedge clk256 or negedge reset_n) begin
        if (!reset_n) begin
            tick <= '0;
            secs <= '0;
        end else begin
            tick <= tick_next;
            secs <= secs_next;
        end
    end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm sounder controller: compares running time to the stored alarm and
// handles ringing, snooze (limited count), stop and auto-timeout.
module alarm_ctrl #(
    parameter int RING_SECS     = 60,
    parameter int SNOOZE_MIN    = 5,
    parameter int MAX_SNOOZE    = 3,
    parameter int TICKS_PER_SEC = alarm_pkg::TICKS_PER_SEC
) (
    input  logic                         clk256,
    input  logic                         reset_n,
    input  logic [alarm_pkg::TIME_W-1:0] current_time,
    input  logic [alarm_pkg::TIME_W-1:0] alarm_time,
    input  logic                         alarm_enable,
    input  logic                         stop_alarm,
    input  logic                         snooze,
    output logic                         sound_alarm,
    output logic                         beep,
    output logic                         snooze_active,
    output logic [2:0]                   snooze_left
);

    import alarm_pkg::alarm_state_e, alarm_pkg::IDLE, alarm_pkg::RINGING,
           alarm_pkg::SNOOZE, alarm_pkg::DONE, alarm_pkg::TICK_W, alarm_pkg::SECS_W;

    localparam logic [SECS_W-1:0] RING_TERM   = SECS_W'(RING_SECS);
    localparam logic [SECS_W-1:0] SNOOZE_TERM = SECS_W'(SNOOZE_MIN * 60);
    localparam logic [2:0]        LEFT_INIT   = 3'(MAX_SNOOZE);
    localparam logic [TICK_W-1:0] BEEP_ON     = TICK_W'(TICKS_PER_SEC / 2);

    alarm_state_e      state;
    alarm_state_e      state_next;
    logic [2:0]        left_next;
    logic              match;
    logic              counting;
    logic              timer_clear;
    logic              timer_expire;
    logic [TICK_W-1:0] tick_next;
    logic [SECS_W-1:0] term;

    assign match       = (current_time == alarm_time);
    assign counting    = (state == RINGING) || (state == SNOOZE);
    assign term        = (state == SNOOZE) ? SNOOZE_TERM : RING_TERM;
    // Counters restart on every state change and rest at zero outside the timed states.
    assign timer_clear = (state_next != state) ||
                         !((state_next == RINGING) || (state_next == SNOOZE));

    sec_timer #(
        .TICKS (TICKS_PER_SEC)
    ) u_sec_timer (
        .clk256    (clk256),
        .reset_n   (reset_n),
        .clear     (timer_clear),
        .run       (counting),
        .term      (term),
        .tick_next (tick_next),
        .expire    (timer_expire)
    );

    always_comb begin
        state_next = state;
        left_next  = snooze_left;
        if (!alarm_enable) begin
            state_next = IDLE;
            left_next  = LEFT_INIT;
        end else begin
            case (state)
                IDLE: begin
                    if (match) begin
                        state_next = RINGING;
                        left_next  = LEFT_INIT;
                    end
                end
                RINGING: begin
                    if (stop_alarm) begin
                        state_next = DONE;
                    end else if (snooze && (snooze_left != 3'd0)) begin
                        state_next = SNOOZE;
                        left_next  = snooze_left - 3'd1;
                    end else if (timer_expire) begin
                        state_next = DONE;
                    end
                end
                SNOOZE: begin
                    if (stop_alarm) begin
                        state_next = DONE;
                    end else if (timer_expire) begin
                        state_next = RINGING;
                    end
                end
                DONE: begin
                    // Hold off until the matching minute has passed so it cannot retrigger.
                    if (!match) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk256 or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            snooze_left   <= LEFT_INIT;
            sound_alarm   <= 1'b0;
            beep          <= 1'b0;
            snooze_active <= 1'b0;
        end else begin
            state         <= state_next;
            snooze_left   <= left_next;
            sound_alarm   <= (state_next == RINGING);
            beep          <= (state_next == RINGING) && (tick_next < BEEP_ON);
            snooze_active <= (state_next == SNOOZE);
        end
    end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl against a countdown-based reference model.
module tb_alarm_ctrl;

    localparam int TPS          = 16;
    localparam int RING_SECS    = 4;
    localparam int SNOOZE_MIN   = 1;
    localparam int MAX_SNOOZE   = 3;
    localparam int RING_TOTAL   = RING_SECS * TPS;
    localparam int SNOOZE_TOTAL = SNOOZE_MIN * 60 * TPS;

    logic        clk256 = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] current_time;
    logic [15:0] alarm_time;
    logic        alarm_enable;
    logic        stop_alarm;
    logic        snooze;
    logic        sound_alarm;
    logic        beep;
    logic        snooze_active;
    logic [2:0]  snooze_left;

    int checks = 0;
    int passes = 0;

    alarm_ctrl #(
        .RING_SECS     (RING_SECS),
        .SNOOZE_MIN    (SNOOZE_MIN),
        .MAX_SNOOZE    (MAX_SNOOZE),
        .TICKS_PER_SEC (TPS)
    ) dut (
        .clk256        (clk256),
        .reset_n       (reset_n),
        .current_time  (current_time),
        .alarm_time    (alarm_time),
        .alarm_enable  (alarm_enable),
        .stop_alarm    (stop_alarm),
        .snooze        (snooze),
        .sound_alarm   (sound_alarm),
        .beep          (beep),
        .snooze_active (snooze_active),
        .snooze_left   (snooze_left)
    );

    always #5 clk256 = ~clk256;

    // Reference model: ringing/snoozing flags with remaining-cycle countdowns.
    logic m_ring, m_snz, m_done;
    int   m_left, m_ring_rem, m_snz_rem;

    always @(posedge clk256 or negedge reset_n) begin
        if (!reset_n) begin
            m_ring <= 1'b0; m_snz <= 1'b0; m_done <= 1'b0;
            m_left <= MAX_SNOOZE; m_ring_rem <= 0; m_snz_rem <= 0;
        end else if (!alarm_enable) begin
            m_ring <= 1'b0; m_snz <= 1'b0; m_done <= 1'b0; m_left <= MAX_SNOOZE;
        end else if (m_ring) begin
            if (stop_alarm) begin
                m_ring <= 1'b0; m_done <= 1'b1;
            end else if (snooze && m_left > 0) begin
                m_ring <= 1'b0; m_snz <= 1'b1; m_left <= m_left - 1; m_snz_rem <= SNOOZE_TOTAL;
            end else if (m_ring_rem == 1) begin
                m_ring <= 1'b0; m_done <= 1'b1;
            end else begin
                m_ring_rem <= m_ring_rem - 1;
            end
        end else if (m_snz) begin
            if (stop_alarm) begin
                m_snz <= 1'b0; m_done <= 1'b1;
            end else if (m_snz_rem == 1) begin
                m_snz <= 1'b0; m_ring <= 1'b1; m_ring_rem <= RING_TOTAL;
            end else begin
                m_snz_rem <= m_snz_rem - 1;
            end
        end else if (m_done) begin
            if (current_time != alarm_time) m_done <= 1'b0;
        end else if (current_time == alarm_time) begin
            m_ring <= 1'b1; m_ring_rem <= RING_TOTAL; m_left <= MAX_SNOOZE;
        end
    end

    logic [5:0] dut_obs, exp_obs;
    assign dut_obs = {sound_alarm, beep, snooze_active, snooze_left};
    assign exp_obs = {m_ring, m_ring && (((RING_TOTAL - m_ring_rem) % TPS) < (TPS / 2)),
                      m_snz, 3'(m_left)};

    task automatic arm_and_ring(input logic [15:0] t);
        alarm_enable = 1'b0;
        @(negedge clk256);
        alarm_enable = 1'b1;
        alarm_time   = t;
        current_time = ~t;
        repeat (2) @(negedge clk256);
        current_time = t;
        @(negedge clk256);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk256);
        checks++;
        if (dut_obs !== {3'b000, 3'(MAX_SNOOZE)})
            $display("[TB] FAIL reset_hold: got %b expected %b", dut_obs, {3'b000, 3'(MAX_SNOOZE)});
        else passes++;
        reset_n = 1'b1;
        arm_and_ring(16'h1234);
        checks++;
        if (sound_alarm !== 1'b1 || dut_obs !== exp_obs)
            $display("[TB] FAIL reset_ring: got %b expected %b", dut_obs, exp_obs);
        else passes++;
        snooze = 1'b1;
        @(negedge clk256);
        snooze = 1'b0;
        repeat (3) @(negedge clk256);
        checks++;
        if (dut_obs !== {3'b001, 3'(MAX_SNOOZE - 1)})
            $display("[TB] FAIL reset_presnooze: got %b expected %b", dut_obs, {3'b001, 3'(MAX_SNOOZE - 1)});
        else passes++;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (dut_obs !== {3'b000, 3'(MAX_SNOOZE)})
            $display("[TB] FAIL reset_async: got %b expected %b", dut_obs, {3'b000, 3'(MAX_SNOOZE)});
        else passes++;
        alarm_enable = 1'b0;
        @(negedge clk256);
        reset_n = 1'b1;
        @(negedge clk256);
        checks++;
        if (dut_obs !== exp_obs || dut_obs !== {3'b000, 3'(MAX_SNOOZE)})
            $display("[TB] FAIL reset_release: got %b expected %b", dut_obs, exp_obs);
        else passes++;
    endtask

    task automatic test_trigger();
        int hi;
        alarm_enable = 1'b1;
        alarm_time   = 16'h0730;
        current_time = 16'h0729;
        repeat (3) @(negedge clk256);
        checks++;
        if (sound_alarm !== 1'b0 || dut_obs !== exp_obs)
            $display("[TB] FAIL trigger_quiet: got %b expected %b", dut_obs, exp_obs);
        else passes++;
        current_time = 16'h0730;
        @(negedge clk256);
        checks++;
        if (sound_alarm !== 1'b1)
            $display("[TB] FAIL trigger_latency: got %b expected 1", sound_alarm);
        else passes++;
        hi = 0;
        for (int i = 0; i < 2 * TPS; i++) begin
            if (i > 0) @(negedge clk256);
            hi += int'(beep);
            checks++;
            if (dut_obs !== exp_obs)
                $display("[TB] FAIL trigger_cycle%0d: got %b expected %b", i, dut_obs, exp_obs);
            else passes++;
        end
        checks++;
        if (hi !== TPS)
            $display("[TB] FAIL beep_duty: got %0d high cycles expected %0d", hi, TPS);
        else passes++;
    endtask

    task automatic test_timeout();
        int n;
        n = 2 * TPS - 1;
        while (sound_alarm === 1'b1 && n < 4 * RING_TOTAL) begin
            @(negedge clk256);
            n++;
            checks++;
            if (dut_obs !== exp_obs)
                $display("[TB] FAIL timeout_track: got %b expected %b", dut_obs, exp_obs);
            else passes++;
        end
        checks++;
        if (n !== RING_TOTAL)
            $display("[TB] FAIL timeout_len: got %0d cycles expected %0d", n, RING_TOTAL);
        else passes++;
        repeat (20) @(negedge clk256);
        checks++;
        if (sound_alarm !== 1'b0 || dut_obs !== exp_obs)
            $display("[TB] FAIL timeout_no_retrigger: got %b expected %b", dut_obs, exp_obs);
        else passes++;
        current_time = 16'h0731;
        repeat (20) @(negedge clk256);
        checks++;
        if (sound_alarm !== 1'b0 || dut_obs !== exp_obs)
            $display("[TB] FAIL timeout_next_min: got %b expected %b", dut_obs, exp_obs);
        else passes++;
    endtask

    task automatic test_snooze();
        int n;
        int r;
        arm_and_ring(16'($urandom));
        for (int k = 0; k <= MAX_SNOOZE; k++) begin
            r = $urandom_range(1, RING_TOTAL - 4);
            repeat (r) begin
                @(negedge clk256);
                checks++;
                if (dut_obs !== exp_obs)
                    $display("[TB] FAIL snooze_ring%0d: got %b expected %b", k, dut_obs, exp_obs);
                else passes++;
            end
            snooze = 1'b1;
            @(negedge clk256);
            snooze = 1'b0;
            if (k < MAX_SNOOZE) begin
                checks++;
                if (dut_obs !== {3'b001, 3'(MAX_SNOOZE - 1 - k)})
                    $display("[TB] FAIL snooze_enter%0d: got %b expected %b", k, dut_obs, {3'b001, 3'(MAX_SNOOZE - 1 - k)});
                else passes++;
                n = 0;
                while (snooze_active === 1'b1 && n < 2 * SNOOZE_TOTAL) begin
                    n++;
                    @(negedge clk256);
                    checks++;
                    if (dut_obs !== exp_obs)
                        $display("[TB] FAIL snooze_track%0d: got %b expected %b", k, dut_obs, exp_obs);
                    else passes++;
                end
                checks++;
                if (n !== SNOOZE_TOTAL || sound_alarm !== 1'b1)
                    $display("[TB] FAIL snooze_len%0d: got %0d cycles sound %b expected %0d cycles sound 1", k, n, sound_alarm, SNOOZE_TOTAL);
                else passes++;
            end else begin
                checks++;
                if ({sound_alarm, snooze_active, snooze_left} !== 5'b10000 || dut_obs !== exp_obs)
                    $display("[TB] FAIL snooze_exhausted: got %b expected %b", dut_obs, exp_obs);
                else passes++;
            end
        end
        n = 0;
        while (sound_alarm === 1'b1 && n < 2 * RING_TOTAL) begin
            n++;
            @(negedge clk256);
        end
        checks++;
        if (dut_obs !== exp_obs || sound_alarm !== 1'b0)
            $display("[TB] FAIL snooze_final_timeout: got %b expected %b", dut_obs, exp_obs);
        else passes++;
        current_time = ~alarm_time;
        repeat (2) @(negedge clk256);
    endtask

    task automatic test_stop();
        arm_and_ring(16'($urandom));
        repeat ($urandom_range(1, RING_TOTAL - 4)) @(negedge clk256);
        stop_alarm = 1'b1;
        @(negedge clk256);
        stop_alarm = 1'b0;
        checks++;
        if (dut_obs !== {3'b000, 3'(MAX_SNOOZE)} || dut_obs !== exp_obs)
            $display("[TB] FAIL stop_ringing: got %b expected %b", dut_obs, {3'b000, 3'(MAX_SNOOZE)});
        else passes++;
        repeat (10) @(negedge clk256);
        checks++;
        if (sound_alarm !== 1'b0 || dut_obs !== exp_obs)
            $display("[TB] FAIL stop_stays_done: got %b expected %b", dut_obs, exp_obs);
        else passes++;

        arm_and_ring(16'($urandom));
        snooze = 1'b1;
        @(negedge clk256);
        snooze = 1'b0;
        repeat ($urandom_range(1, 100)) @(negedge clk256);
        stop_alarm = 1'b1;
        @(negedge clk256);
        stop_alarm = 1'b0;
        checks++;
        if (dut_obs !== {3'b000, 3'(MAX_SNOOZE - 1)} || dut_obs !== exp_obs)
            $display("[TB] FAIL stop_snoozing: got %b expected %b", dut_obs, {3'b000, 3'(MAX_SNOOZE - 1)});
        else passes++;
        repeat (SNOOZE_TOTAL + 10) @(negedge clk256);
        checks++;
        if (sound_alarm !== 1'b0 || dut_obs !== exp_obs)
            $display("[TB] FAIL stop_no_resume: got %b expected %b", dut_obs, exp_obs);
        else passes++;

        arm_and_ring(16'($urandom));
        repeat ($urandom_range(1, RING_TOTAL - 4)) @(negedge clk256);
        stop_alarm = 1'b1;
        snooze     = 1'b1;
        @(negedge clk256);
        stop_alarm = 1'b0;
        snooze     = 1'b0;
        checks++;
        if (dut_obs !== {3'b000, 3'(MAX_SNOOZE)} || dut_obs !== exp_obs)
            $display("[TB] FAIL stop_beats_snooze: got %b expected %b", dut_obs, {3'b000, 3'(MAX_SNOOZE)});
        else passes++;
        current_time = ~alarm_time;
        repeat (2) @(negedge clk256);
    endtask

    task automatic test_enable_drop();
        arm_and_ring(16'($urandom));
        snooze = 1'b1;
        @(negedge clk256);
        snooze = 1'b0;
        repeat ($urandom_range(1, 50)) @(negedge clk256);
        alarm_enable = 1'b0;
        @(negedge clk256);
        checks++;
        if (dut_obs !== {3'b000, 3'(MAX_SNOOZE)} || dut_obs !== exp_obs)
            $display("[TB] FAIL enable_drop: got %b expected %b", dut_obs, {3'b000, 3'(MAX_SNOOZE)});
        else passes++;
        alarm_enable = 1'b1;
        @(negedge clk256);
        checks++;
        if (dut_obs !== {3'b110, 3'(MAX_SNOOZE)} || dut_obs !== exp_obs)
            $display("[TB] FAIL enable_rering: got %b expected %b", dut_obs, {3'b110, 3'(MAX_SNOOZE)});
        else passes++;
    endtask

    task automatic test_random();
        alarm_time = 16'($urandom);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk256);
            checks++;
            if (dut_obs !== exp_obs)
                $display("[TB] FAIL random_cycle%0d: got %b expected %b", i, dut_obs, exp_obs);
            else passes++;
            stop_alarm   = ($urandom_range(0, 99) < 1);
            snooze       = ($urandom_range(0, 99) < 3);
            alarm_enable = !($urandom_range(0, 999) < 2);
            if ($urandom_range(0, 99) < 3)
                current_time = ($urandom_range(0, 1) == 1) ? alarm_time : alarm_time + 16'd1;
            if ($urandom_range(0, 999) < 3)
                alarm_time = 16'($urandom);
        end
        stop_alarm = 1'b0;
        snooze     = 1'b0;
    endtask

    initial begin
        current_time = 16'h0000;
        alarm_time   = 16'h0730;
        alarm_enable = 1'b0;
        stop_alarm   = 1'b0;
        snooze       = 1'b0;
        test_reset();
        test_trigger();
        test_timeout();
        test_snooze();
        test_stop();
        test_enable_drop();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
